// File: rtl/axi4_lite_master_param.sv
// rtl/axi4_lite_master_param.sv - parameterised AXI4-Lite master with single-command request/response port
module axi4_lite_master_param #(
  parameter int         ADDR_WIDTH   = 32,
  parameter int         DATA_WIDTH   = 32,
  parameter int         STRB_WIDTH   = DATA_WIDTH / 8,
  parameter logic [2:0] PROT_DEFAULT = 3'b000
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic [2:0]            AWPROT,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic [STRB_WIDTH-1:0] WSTRB,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic [2:0]            ARPROT,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RVALID,
  output logic                  RREADY,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [STRB_WIDTH-1:0] req_wstrb,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_err
);

  typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_R} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  aw_done;
  logic                  w_done;
  logic                  aw_hs;
  logic                  w_hs;

  // One captured address serves both channels; only one of them is ever valid.
  assign AWADDR = addr_q;
  assign ARADDR = addr_q;
  assign AWPROT = PROT_DEFAULT;
  assign ARPROT = PROT_DEFAULT;
  assign aw_hs  = AWVALID & AWREADY;
  assign w_hs   = WVALID & WREADY;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state     <= IDLE;
      addr_q    <= '0;
      WDATA     <= '0;
      WSTRB     <= '0;
      AWVALID   <= 1'b0;
      WVALID    <= 1'b0;
      BREADY    <= 1'b0;
      ARVALID   <= 1'b0;
      RREADY    <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= 2'b00;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            addr_q    <= req_addr;
            WDATA     <= req_wdata;
            WSTRB     <= req_wstrb;
            req_ready <= 1'b0;
            if (req_write) begin
              state   <= WR;
              AWVALID <= 1'b1;
              WVALID  <= 1'b1;
            end else begin
              state   <= RD_A;
              ARVALID <= 1'b1;
            end
          end
        end
        WR: begin
          if (aw_hs) begin
            AWVALID <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            WVALID <= 1'b0;
            w_done <= 1'b1;
          end
          // Same-cycle completion counts as done, so check the live handshakes too.
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            state   <= WR_B;
            BREADY  <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end
        end
        WR_B: begin
          if (BVALID) begin
            BREADY    <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= BRESP;
            rsp_err   <= BRESP[1];
            rsp_valid <= 1'b1;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        RD_A: begin
          if (ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            state   <= RD_R;
          end
        end
        RD_R: begin
          if (RVALID) begin
            RREADY    <= 1'b0;
            rsp_rdata <= RDATA;
            rsp_resp  <= RRESP;
            rsp_err   <= RRESP[1];
            rsp_valid <= 1'b1;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_master_param.sv
// tb/tb_axi4_lite_master_param.sv - scoreboard bench for axi4_lite_master_param with a delay-configurable slave
module tb_axi4_lite_master_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] AWADDR, ARADDR, WDATA, RDATA, req_addr, req_wdata, rsp_rdata;
  logic [3:0]  WSTRB, req_wstrb;
  logic [2:0]  AWPROT, ARPROT;
  logic [1:0]  BRESP, RRESP, rsp_resp;
  logic AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY;
  logic req_valid, req_ready, req_write, rsp_valid, rsp_err;

  axi4_lite_master_param #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .ACLK(clk), .ARESETn(rst_n),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_err(rsp_err)
  );

  logic [15:0] d64_awaddr, d64_araddr, d64_req_addr;
  logic [63:0] d64_wdata, d64_rdata, d64_req_wdata, d64_rsp_rdata;
  logic [7:0]  d64_wstrb, d64_req_wstrb;
  logic [2:0]  d64_awprot, d64_arprot;
  logic [1:0]  d64_bresp, d64_rresp, d64_rsp_resp;
  logic d64_awvalid, d64_awready, d64_wvalid, d64_wready, d64_bvalid, d64_bready;
  logic d64_arvalid, d64_arready, d64_rvalid, d64_rready;
  logic d64_req_valid, d64_req_ready, d64_req_write, d64_rsp_valid, d64_rsp_err;

  axi4_lite_master_param #(.ADDR_WIDTH(16), .DATA_WIDTH(64)) dut64 (
    .ACLK(clk), .ARESETn(rst_n),
    .AWADDR(d64_awaddr), .AWPROT(d64_awprot), .AWVALID(d64_awvalid), .AWREADY(d64_awready),
    .WDATA(d64_wdata), .WSTRB(d64_wstrb), .WVALID(d64_wvalid), .WREADY(d64_wready),
    .BRESP(d64_bresp), .BVALID(d64_bvalid), .BREADY(d64_bready),
    .ARADDR(d64_araddr), .ARPROT(d64_arprot), .ARVALID(d64_arvalid), .ARREADY(d64_arready),
    .RDATA(d64_rdata), .RRESP(d64_rresp), .RVALID(d64_rvalid), .RREADY(d64_rready),
    .req_valid(d64_req_valid), .req_ready(d64_req_ready), .req_write(d64_req_write),
    .req_addr(d64_req_addr), .req_wdata(d64_req_wdata), .req_wstrb(d64_req_wstrb),
    .rsp_valid(d64_rsp_valid), .rsp_rdata(d64_rsp_rdata), .rsp_resp(d64_rsp_resp), .rsp_err(d64_rsp_err)
  );

  int passed = 0;
  int total  = 0;

  // Slave model: per-channel ready/valid delays, updated on the falling edge.
  int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  logic [31:0] r_data_cfg = 32'h0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  bit aw_seen = 0, w_seen = 0, ar_seen = 0, b_rdy_q = 0, r_rdy_q = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
      BRESP = 2'b00; RRESP = 2'b00; RDATA = 32'h0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      aw_seen = 0; w_seen = 0; ar_seen = 0; b_rdy_q = 0; r_rdy_q = 0;
    end else begin
      if (BVALID && b_rdy_q) begin BVALID = 0; aw_seen = 0; w_seen = 0; b_cnt = 0; end
      if (RVALID && r_rdy_q) begin RVALID = 0; ar_seen = 0; r_cnt = 0; end
      if (aw_seen && w_seen && !BVALID) begin
        if (b_cnt >= b_delay) begin BVALID = 1; BRESP = b_resp_cfg; end else b_cnt++;
      end
      if (ar_seen && !RVALID) begin
        if (r_cnt >= r_delay) begin RVALID = 1; RDATA = r_data_cfg; RRESP = r_resp_cfg; end else r_cnt++;
      end
      AWREADY = 0; WREADY = 0; ARREADY = 0;
      if (AWVALID && !aw_seen) begin
        if (aw_cnt >= aw_delay) begin AWREADY = 1; aw_seen = 1; aw_cnt = 0; end else aw_cnt++;
      end
      if (WVALID && !w_seen) begin
        if (w_cnt >= w_delay) begin WREADY = 1; w_seen = 1; w_cnt = 0; end else w_cnt++;
      end
      if (ARVALID && !ar_seen) begin
        if (ar_cnt >= ar_delay) begin ARREADY = 1; ar_seen = 1; ar_cnt = 0; end else ar_cnt++;
      end
      b_rdy_q = BREADY;
      r_rdy_q = RREADY;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      total++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected_rsp: got rdata=%h resp=%b, none expected", rsp_rdata, rsp_resp);
      end else begin
        mon_e = sb.pop_front();
        if (rsp_rdata !== mon_e.rdata || rsp_resp !== mon_e.resp || rsp_err !== mon_e.resp[1])
          $display("FAIL sb_rsp: got rdata=%h resp=%b err=%b, want rdata=%h resp=%b err=%b",
                   rsp_rdata, rsp_resp, rsp_err, mon_e.rdata, mon_e.resp, mon_e.resp[1]);
        else
          passed++;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [31:0] erd, input logic [1:0] eresp,
                      input bit expect_rsp);
    int n = 0;
    exp_t x;
    req_valid = 1; req_write = wr; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
    while (req_ready !== 1'b1 && n < 50) begin tick(); n++; end
    if (n >= 50) begin total++; $display("FAIL send_timeout: req_ready=%b, want 1", req_ready); end
    x.rdata = erd; x.resp = eresp;
    if (expect_rsp) sb.push_back(x);
    tick();
    req_valid = 0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin tick(); n++; end
    if (n >= 40) begin total++; $display("FAIL rsp_timeout: rsp_valid=%b, want 1", rsp_valid); end
  endtask

  task automatic test_reset();
    tick(); tick();
    total++;
    if ({AWVALID, WVALID, BREADY, ARVALID, RREADY, req_ready, rsp_valid, rsp_err} !== 8'h00 ||
        rsp_rdata !== 32'h0 || rsp_resp !== 2'b00 || AWADDR !== 32'h0 || WDATA !== 32'h0 || WSTRB !== 4'h0)
      $display("FAIL reset_outputs: vr=%b rdata=%h resp=%b addr=%h, want all 0",
               {AWVALID, WVALID, BREADY, ARVALID, RREADY, req_ready, rsp_valid, rsp_err}, rsp_rdata, rsp_resp, AWADDR);
    else passed++;
    rst_n = 1;
    tick();
    total++;
    if (req_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", req_ready); else passed++;
  endtask

  task automatic test_write_zero_wait();
    aw_delay = 0; w_delay = 0; b_delay = 0; b_resp_cfg = 2'b00;
    send(1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 32'h0, 2'b00, 1);
    total++;
    if (AWVALID !== 1 || WVALID !== 1 || AWADDR !== 32'h8 || WDATA !== 32'hDEAD_BEEF || WSTRB !== 4'hF ||
        AWPROT !== 3'b000 || BREADY !== 0)
      $display("FAIL wr_cycle1: awv=%b wv=%b addr=%h data=%h strb=%h br=%b, want 1 1 8 deadbeef f 0",
               AWVALID, WVALID, AWADDR, WDATA, WSTRB, BREADY);
    else passed++;
    tick();
    total++;
    if (BREADY !== 1 || AWVALID !== 0 || WVALID !== 0)
      $display("FAIL wr_cycle2: br=%b awv=%b wv=%b, want 1 0 0", BREADY, AWVALID, WVALID);
    else passed++;
    tick();
    total++;
    if (rsp_valid !== 1 || rsp_resp !== 2'b00 || rsp_err !== 0 || req_ready !== 1)
      $display("FAIL wr_cycle3: rv=%b resp=%b err=%b rr=%b, want 1 00 0 1", rsp_valid, rsp_resp, rsp_err, req_ready);
    else passed++;
    tick();
  endtask

  task automatic test_write_w_first();
    int aw_hs = -1, w_hs = -1, rsps = 0;
    bit addr_bad = 0, bready_early = 0, wv_after = 0;
    aw_delay = 4; w_delay = 1; b_delay = 1;
    send(1, 32'h0000_0044, 32'hA5A5_0F0F, 4'h6, 32'h0, 2'b00, 1);
    for (int i = 0; i < 30; i++) begin
      if (AWVALID && AWADDR !== 32'h44) addr_bad = 1;
      if (BREADY && (aw_hs < 0 || w_hs < 0)) bready_early = 1;
      if (w_hs >= 0 && WVALID) wv_after = 1;
      if (rsp_valid) rsps++;
      if (AWVALID && AWREADY && aw_hs < 0) aw_hs = i;
      if (WVALID && WREADY && w_hs < 0) w_hs = i;
      tick();
    end
    total++;
    if (!(w_hs >= 0 && aw_hs > w_hs)) $display("FAIL wfirst_order: w_hs=%0d aw_hs=%0d, want w before aw", w_hs, aw_hs);
    else passed++;
    total++;
    if (addr_bad || wv_after) $display("FAIL wfirst_stable: addr_bad=%0d wvalid_after_hs=%0d, want 0 0", addr_bad, wv_after);
    else passed++;
    total++;
    if (bready_early) $display("FAIL wfirst_bready_early: got 1 want 0"); else passed++;
    total++;
    if (rsps != 1) $display("FAIL wfirst_rsp_count: got %0d want 1", rsps); else passed++;
    aw_delay = 0; w_delay = 0; b_delay = 0;
  endtask

  task automatic test_read_delayed();
    int ar_hs = -1, rsps = 0;
    bit addr_bad = 0, rready_early = 0;
    logic [31:0] got = 32'h0;
    ar_delay = 2; r_delay = 3; r_data_cfg = 32'h1234_5678; r_resp_cfg = 2'b00;
    send(0, 32'h0000_000C, 32'hFFFF_FFFF, 4'hF, 32'h1234_5678, 2'b00, 1);
    for (int i = 0; i < 30; i++) begin
      if (ARVALID && ARADDR !== 32'hC) addr_bad = 1;
      if (RREADY && ar_hs < 0) rready_early = 1;
      if (rsp_valid) begin rsps++; got = rsp_rdata; end
      if (ARVALID && ARREADY && ar_hs < 0) ar_hs = i;
      tick();
    end
    total++;
    if (addr_bad || rready_early || ar_hs != 2)
      $display("FAIL rd_ar_phase: addr_bad=%0d rready_early=%0d ar_hs=%0d, want 0 0 2", addr_bad, rready_early, ar_hs);
    else passed++;
    total++;
    if (rsps != 1 || got !== 32'h1234_5678) $display("FAIL rd_rsp: count=%0d data=%h, want 1 12345678", rsps, got);
    else passed++;
    ar_delay = 0; r_delay = 0;
  endtask

  task automatic test_error();
    r_resp_cfg = 2'b10; r_data_cfg = 32'hBAD0_0001;
    send(0, 32'h0000_0100, 32'h0, 4'h0, 32'hBAD0_0001, 2'b10, 1);
    wait_rsp();
    total++;
    if (rsp_resp !== 2'b10 || rsp_err !== 1 || req_ready !== 1)
      $display("FAIL err_read: resp=%b err=%b rr=%b, want 10 1 1", rsp_resp, rsp_err, req_ready);
    else passed++;
    r_resp_cfg = 2'b00;
    b_resp_cfg = 2'b11;
    send(1, 32'h0000_0104, 32'h0000_0055, 4'h1, 32'h0, 2'b11, 1);
    wait_rsp();
    total++;
    if (rsp_resp !== 2'b11 || rsp_err !== 1 || rsp_rdata !== 32'h0)
      $display("FAIL err_write: resp=%b err=%b rdata=%h, want 11 1 0", rsp_resp, rsp_err, rsp_rdata);
    else passed++;
    b_resp_cfg = 2'b00;
    tick();
  endtask

  task automatic test_back_to_back();
    int c0;
    r_data_cfg = 32'h0BAD_CAFE;
    send(1, 32'h0000_0200, 32'h1111_2222, 4'h3, 32'h0, 2'b00, 1);
    wait_rsp();
    c0 = cyc;
    total++;
    if (req_ready !== 1) $display("FAIL b2b_ready_on_rsp: got %b want 1", req_ready); else passed++;
    send(0, 32'h0000_0204, 32'h0, 4'h0, 32'h0BAD_CAFE, 2'b00, 1);
    wait_rsp();
    total++;
    if (cyc - c0 != 3) $display("FAIL b2b_read_latency: got %0d want 3", cyc - c0); else passed++;
    total++;
    if (rsp_err !== 0 || rsp_rdata !== 32'h0BAD_CAFE) $display("FAIL b2b_read_data: err=%b data=%h, want 0 0badcafe", rsp_err, rsp_rdata);
    else passed++;
    tick();
  endtask

  task automatic test_width64();
    int n = 0;
    d64_req_valid = 1; d64_req_write = 1; d64_req_addr = 16'h0010;
    d64_req_wdata = 64'h0011_2233_4455_6677; d64_req_wstrb = 8'h0F;
    tick();
    d64_req_valid = 0;
    total++;
    if (d64_wvalid !== 1 || d64_wdata !== 64'h0011_2233_4455_6677 || d64_wstrb !== 8'h0F || d64_awaddr !== 16'h0010)
      $display("FAIL w64_drive: wv=%b data=%h strb=%h addr=%h, want 1 0011223344556677 0f 0010",
               d64_wvalid, d64_wdata, d64_wstrb, d64_awaddr);
    else passed++;
    while (d64_rsp_valid !== 1'b1 && n < 20) begin tick(); n++; end
    total++;
    if (d64_rsp_valid !== 1 || d64_rsp_rdata !== 64'h0 || d64_rsp_resp !== 2'b00)
      $display("FAIL w64_rsp: rv=%b rdata=%h resp=%b, want 1 0 00", d64_rsp_valid, d64_rsp_rdata, d64_rsp_resp);
    else passed++;
    tick();
  endtask

  task automatic test_reset_in_wr_b();
    int rsps = 0;
    b_delay = 5;
    send(1, 32'h0000_0300, 32'hCAFE_F00D, 4'hF, 32'h0, 2'b00, 0);
    tick();
    total++;
    if (BREADY !== 1) $display("FAIL rst_pre_wr_b: bready=%b want 1", BREADY); else passed++;
    rst_n = 0;
    #1;
    total++;
    if ({AWVALID, WVALID, BREADY, ARVALID, RREADY, req_ready, rsp_valid} !== 7'h00)
      $display("FAIL rst_async_outputs: got %b want 0000000", {AWVALID, WVALID, BREADY, ARVALID, RREADY, req_ready, rsp_valid});
    else passed++;
    tick();
    rst_n = 1;
    b_delay = 0;
    tick();
    total++;
    if (req_ready !== 1) $display("FAIL rst_release_ready: got %b want 1", req_ready); else passed++;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) rsps++;
      tick();
    end
    total++;
    if (rsps != 0) $display("FAIL rst_no_rsp: got %0d pulses want 0", rsps); else passed++;
  endtask

  initial begin
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    d64_req_valid = 0; d64_req_write = 0; d64_req_addr = '0; d64_req_wdata = '0; d64_req_wstrb = '0;
    d64_awready = 1; d64_wready = 1; d64_bvalid = 1; d64_bresp = 2'b00;
    d64_arready = 1; d64_rvalid = 1; d64_rresp = 2'b00; d64_rdata = 64'hFFFF_0000_FFFF_0000;
    test_reset();
    test_write_zero_wait();
    test_write_w_first();
    test_read_delayed();
    test_error();
    test_back_to_back();
    test_width64();
    test_reset_in_wr_b();
    tick(); tick();
    total++;
    if (sb.size() != 0) $display("FAIL sb_drain: %0d responses outstanding, want 0", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
